// File: rtl/dk_sound_pkg.sv
// dk_sound_pkg: shared types and fixed-point helpers for the sound blocks.
//   osc555_state_t : 555 oscillator state encoding
//   Q15_ONE/SHIFT  : Q1.15 coefficient scale
//   sat_add        : signed add saturated to a given two's-complement width
package dk_sound_pkg;

    typedef enum logic [1:0] {CHARGE, DISCHARGE, STALL} osc555_state_t;

    localparam int Q15_ONE   = 32768;
    localparam int Q15_SHIFT = 15;

    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 width
    );
        logic signed [63:0] s, hi, lo;
        s  = a + b;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        return (s > hi) ? hi : ((s < lo) ? lo : s);
    endfunction

endpackage

// File: rtl/q15_mul_shift_sat.sv
// q15_mul_shift_sat: signed x times unsigned Q1.15 coefficient, >>>15 (floor), saturated.
//   x_i : signed input sample (IN_W bits)
//   k_i : Q1.15 coefficient, treated as non-negative
//   y_o : saturated product (OUT_W bits)
module q15_mul_shift_sat
    import dk_sound_pkg::*;
#(
    parameter int IN_W   = 21,
    parameter int OUT_W  = 20,
    parameter int PROD_W = 36
) (
    input  logic signed [IN_W-1:0]  x_i,
    input  logic        [15:0]      k_i,
    output logic signed [OUT_W-1:0] y_o
);

    localparam logic signed [PROD_W-1:0] HI = PROD_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [PROD_W-1:0] LO = -HI - PROD_W'(1);

    logic signed [PROD_W-1:0] xe, ke, prod, shifted;

    assign xe      = PROD_W'(x_i);
    assign ke      = PROD_W'($signed({1'b0, k_i}));
    assign prod    = xe * ke;
    assign shifted = prod >>> Q15_SHIFT;
    assign y_o     = (shifted > HI) ? OUT_W'(HI) : (shifted < LO) ? OUT_W'(LO) : OUT_W'(shifted);

endmodule

// File: rtl/astable_555_vco.sv
// astable_555_vco: 555 astable oscillator whose thresholds follow pin-5 v_control.
//   clk, rst_n   : clock, async active-low reset
//   clk_en       : sample strobe; all state advances only on it
//   v_control    : upper threshold (lower is v_control/2)
//   vcc          : charge target and output high level
//   square_out   : vcc while high, 0 while low
//   out_high     : oscillator output level
//   edge_pulse   : one clk pulse on every out_high change
//   half_period  : clk_en count of the last completed half-period (saturating)
module astable_555_vco
    import dk_sound_pkg::*;
#(
    parameter int          signal_width = 16,
    parameter int          CAP_FRAC     = 4,
    parameter logic [15:0] CHARGE_K     = 16'd449,
    parameter logic [15:0] DISCHARGE_K  = 16'd1057,
    parameter int          VCTL_MIN     = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clk_en,
    input  logic signed [signal_width-1:0] v_control,
    input  logic signed [signal_width-1:0] vcc,
    output logic signed [signal_width-1:0] square_out,
    output logic                           out_high,
    output logic                           edge_pulse,
    output logic        [15:0]             half_period
);

    localparam int CW = signal_width + CAP_FRAC;
    localparam logic signed [signal_width-1:0] VMIN = signal_width'(VCTL_MIN);

    osc555_state_t                  state_q, state_d;
    logic signed [CW-1:0]           v_cap_q, v_cap_d;
    logic signed [signal_width-1:0] square_q;
    logic                           out_high_q, edge_q;
    logic        [15:0]             hp_q, hp_d, cnt_q, cnt_d, cnt_inc;
    logic signed [CW-1:0]           vctl_up, vctl_lo, vcc_up, charge_term, dis_term;
    logic signed [CW:0]             diff;
    logic signed [63:0]             sum;
    logic                           stall, high_d, toggle, stall_entry;

    // Thresholds and charge target in cap units (CAP_FRAC extra LSBs).
    assign vctl_up = {v_control, {CAP_FRAC{1'b0}}};
    assign vctl_lo = {v_control[signal_width-1], v_control[signal_width-1:1], {CAP_FRAC{1'b0}}};
    assign vcc_up  = {vcc, {CAP_FRAC{1'b0}}};
    assign diff    = {vcc_up[CW-1], vcc_up} - {v_cap_q[CW-1], v_cap_q};
    assign stall   = v_control <= VMIN;

    q15_mul_shift_sat #(.IN_W(CW + 1), .OUT_W(CW), .PROD_W(CW + 16)) u_charge (
        .x_i (diff),
        .k_i (CHARGE_K),
        .y_o (charge_term)
    );

    q15_mul_shift_sat #(.IN_W(CW), .OUT_W(CW), .PROD_W(CW + 16)) u_discharge (
        .x_i (v_cap_q),
        .k_i (DISCHARGE_K),
        .y_o (dis_term)
    );

    always_comb begin
        state_d     = stall ? STALL
                    : (state_q == CHARGE)    ? ((v_cap_q >= vctl_up) ? DISCHARGE : CHARGE)
                    : (state_q == DISCHARGE) ? ((v_cap_q <= vctl_lo) ? CHARGE : DISCHARGE)
                    : CHARGE;
        // The cap equation follows the state being entered on this step.
        sum         = (state_d == CHARGE) ? sat_add(64'(v_cap_q), 64'(charge_term), CW)
                                          : sat_add(64'(v_cap_q), -64'(dis_term), CW);
        v_cap_d     = (sum < 0) ? '0 : CW'(sum);
        high_d      = state_d == CHARGE;
        toggle      = high_d != out_high_q;
        stall_entry = (state_d == STALL) && (state_q != STALL);
        cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
        cnt_d       = (stall_entry || toggle) ? '0 : cnt_inc;
        // Stall entry drops the output too, but that half-period is not reported.
        hp_d        = (toggle && !stall_entry) ? cnt_inc : hp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CHARGE;
            v_cap_q    <= '0;
            out_high_q <= 1'b0;
            square_q   <= '0;
            edge_q     <= 1'b0;
            hp_q       <= '0;
            cnt_q      <= '0;
        end else begin
            edge_q <= clk_en && toggle;
            if (clk_en) begin
                state_q    <= state_d;
                v_cap_q    <= v_cap_d;
                out_high_q <= high_d;
                square_q   <= high_d ? vcc : '0;
                hp_q       <= hp_d;
                cnt_q      <= cnt_d;
            end
        end
    end

    assign square_out  = square_q;
    assign out_high    = out_high_q;
    assign edge_pulse  = edge_q;
    assign half_period = hp_q;

endmodule

// File: tb/tb_astable_555_vco.sv
// tb_astable_555_vco: randomized bench against an arithmetic model of the 555 VCO.
module tb_astable_555_vco;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               clk_en = 1'b0;
    logic signed [15:0] v_control = 16'sh4000;
    logic signed [15:0] vcc = 16'sh6000;
    logic signed [15:0] square_out;
    logic               out_high, edge_pulse;
    logic        [15:0] half_period;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: 0 charging, 1 discharging, 2 stalled.
    int                 m_vcap, m_state, m_high, m_cnt, m_hp, m_edge;
    logic signed [15:0] m_sq;

    astable_555_vco dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_en      (clk_en),
        .v_control   (v_control),
        .vcc         (vcc),
        .square_out  (square_out),
        .out_high    (out_high),
        .edge_pulse  (edge_pulse),
        .half_period (half_period)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_vcap  = 0;
        m_state = 0;
        m_high  = 0;
        m_cnt   = 0;
        m_hp    = 0;
        m_edge  = 0;
        m_sq    = 0;
    endtask

    task automatic model_step();
        int     vc, vv, ns, nh, nv;
        longint delta, s;
        vc = int'(v_control);
        vv = int'(vcc);
        if (vc <= 64)          ns = 2;
        else if (m_state == 0) ns = (m_vcap >= vc * 16) ? 1 : 0;
        else if (m_state == 1) ns = (m_vcap <= (vc >>> 1) * 16) ? 0 : 1;
        else                   ns = 0;
        if (ns == 0) delta = (longint'(vv * 16 - m_vcap) * 449) >>> 15;
        else         delta = -((longint'(m_vcap) * 1057) >>> 15);
        s = longint'(m_vcap) + delta;
        if (s > 524287) s = 524287;
        if (s < 0)      s = 0;
        nv = int'(s);
        nh = (ns == 0) ? 1 : 0;
        m_edge = (nh != m_high) ? 1 : 0;
        if (ns == 2 && m_state != 2) m_cnt = 0;
        else if (m_edge == 1) begin
            m_hp  = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
            m_cnt = 0;
        end else m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
        m_sq    = (nh == 1) ? vcc : 16'sd0;
        m_high  = nh;
        m_state = ns;
        m_vcap  = nv;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".out_high"},    {31'd0, out_high},     32'(m_high));
        check({tag, ".square_out"},  {16'd0, square_out},   {16'd0, m_sq});
        check({tag, ".edge_pulse"},  {31'd0, edge_pulse},   32'(m_edge));
        check({tag, ".half_period"}, {16'd0, half_period},  32'(m_hp));
    endtask

    task automatic step(input bit en, input string tag);
        clk_en = en;
        @(posedge clk);
        if (en) model_step();
        else m_edge = 0;
        #1;
        compare_all(tag);
    endtask

    task automatic run(input int n, input bit free_run, input string tag);
        for (int i = 0; i < n; i++) step(free_run ? 1'b1 : 1'($urandom_range(0, 1)), tag);
    endtask

    initial begin
        model_reset();
        // Reset held while strobes run: everything stays at zero.
        for (int i = 0; i < 4; i++) begin
            clk_en = 1'b1;
            @(posedge clk);
            #1;
            compare_all("in_reset");
        end
        rst_n = 1'b1;
        step(1'b1, "first_step");
        check("first_edge", {31'd0, edge_pulse}, 32'd1);
        check("first_sq", {16'd0, square_out}, 32'h0000_6000);

        run(1500, 1'b0, "osc_4000");
        v_control = 16'sh3000;
        run(800, 1'b0, "osc_3000");

        v_control = 16'sd40;
        run(300, 1'b0, "stall");
        check("stall_low", {31'd0, out_high}, 32'd0);
        v_control = 16'sh4000;
        step(1'b1, "unstall");
        check("unstall_edge", {31'd0, edge_pulse}, 32'd1);
        run(200, 1'b0, "restart");

        // Async reset pulse in the middle of a discharge.
        for (int k = 0; k < 1000 && m_state != 1; k++) step(1'b1, "seek_dis");
        check("reached_dis", 32'(m_state), 32'd1);
        #2 rst_n = 1'b0;
        model_reset();
        #1 compare_all("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        compare_all("rst_release");
        run(300, 1'b0, "after_rst");

        vcc = 16'sh7FFF;
        v_control = 16'sh7FFF;
        run(2000, 1'b1, "full_scale");

        // Random supplies/thresholds, including negative vcc and near-stall controls.
        for (int seg = 0; seg < 60; seg++) begin
            vcc = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       v_control = 16'($urandom_range(0, 128));
                1:       v_control = 16'($urandom);
                default: v_control = 16'($urandom_range(16'h0800, 16'h7FFF));
            endcase
            run(int'($urandom_range(1, 150)), 1'($urandom_range(0, 1)), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
